opendap_sw_dp_regs: RTL and testbench
=====================================

// Module: opendap_sw_dp_regs
// PURPOSE
// DP register file and AP-access sequencer directly downstream of the SW-DP serial comms block.
// Decodes parallel DP/AP accesses and returns read data in the access cycle.
// Holds DP registers DPIDR, CTRL/STAT, SELECT, RDBUFF, ABORT, and the TARGETID/DLPIDR banks.
// Produces the WAIT/FAULT/protocol-error qualifiers for the ACK, and runs posted AP transactions
// on a req/ack AP bus.
// PARAMETERS
// DPIDR     32'h2ba01477  value returned on DPIDR read
// TARGETID  32'h00000001  value returned on bank-2 read of addr 1
// DLPIDR    32'h00000001  value returned on bank-3 read of addr 1
// PORTS
// swclk               in   1   SWD clock; all state on posedge
// rst                 in   1   asynchronous, active-high reset
// bus_addr            in   2   DP/AP register address A[3:2]
// bus_r_nw            in   1   1 = read
// bus_ap_ndp          in   1   1 = AP access
// bus_wdata           in   32  write data
// bus_en              in   1   access strobe, 1 cycle
// bus_rdata           out  32  read data, combinational, valid whenever bus_en && bus_r_nw
// dp_set_wdataerr     in   1   set CTRL/STAT.WDATAERR
// dp_set_stickyorun   in   1   set CTRL/STAT.STICKYORUN
// dp_clear_readok     in   1   clear CTRL/STAT.READOK
// dp_orundetect       out  1   CTRL/STAT.ORUNDETECT
// dp_acc_fault        out  1   AP header && any of STICKYERR/STICKYORUN/WDATAERR set (comb)
// dp_acc_protocol_err out  1   current header is an illegal access (comb)
// ap_rdy              out  1   !ap_busy
// ap_req              out  1   AP request; held high until ap_ack
// ap_sel              out  8   SELECT.APSEL, captured at launch
// ap_addr             out  6   {SELECT.APBANKSEL, bus_addr}, captured at launch
// ap_r_nw             out  1   captured at launch
// ap_wdata            out  32  captured at launch
// ap_ack              in   1   1-cycle completion
// ap_err              in   1   qualifies ap_ack: slave error
// ap_rdata            in   32  qualifies ap_ack && ap_r_nw
// ap_abort            out  1   1-cycle pulse on ABORT.DAPABORT
// cdbgpwrupreq        out  1   CTRL/STAT[28]
// csyspwrupreq        out  1   CTRL/STAT[30]
// cdbgpwrupack        in   1   async; 2-flop synchronised, shown at CTRL/STAT[29]
// csyspwrupack        in   1   async; 2-flop synchronised, shown at CTRL/STAT[31]
// BEHAVIOUR
// - Reset: all registers 0. ap_req=0, ap_abort=0, ap_busy=0, pwrupreqs=0, rdbuff=0.
// - DP reads:
//   - addr0 -> DPIDR
//   - addr1 -> bank by SELECT[3:0]: 0 CTRL/STAT, 1 DLCR=0x40, 2 TARGETID, 3 DLPIDR, else 0
//   - addr2 (RESEND) -> 0 (the upstream block ignores it)
//   - addr3 -> rdbuff, no side effect
// - DP writes (on bus_en):
//   - addr0 = ABORT: [0] DAPABORT, [2] clear STICKYERR, [3] clear WDATAERR, [4] clear STICKYORUN
//   - addr1 bank0 = CTRL/STAT: writable bits [0], [28], [30] only
//   - addr2 = SELECT
//   - addr3 = TARGETSEL: consumed upstream, ignored here
// - Protocol error: write to addr1 with SELECT[3:0] != 0.
//   dp_acc_protocol_err is combinational on the bus_* inputs; the register is not written.
// - AP access on bus_en:
//   - Launch: ap_busy=1, ap_req=1 next cycle; sel/addr/r_nw/wdata latched.
//   - AP read: bus_rdata = rdbuff, i.e. the previous result (posted).
//   - Upstream never issues an AP access while !ap_rdy; if one arrives, it is ignored.
// - Completion on ap_ack:
//   - ap_req=0 and ap_busy=0 next cycle.
//   - ap_err: set STICKYERR.
//   - Read with no error: rdbuff <= ap_rdata and set READOK.
//   - Read with ap_err: rdbuff unchanged and READOK cleared.
// - DAPABORT write:
//   - Effective immediately.
//   - ap_abort pulses for 1 cycle, ap_req drops, ap_busy=0.
//   - An ap_ack arriving in the same cycle is discarded.
// - Sticky precedence: set beats clear in the same cycle (dp_set_* or ap_err vs ABORT clear).
//   READOK set beats dp_clear_readok.
// - Power acks: 2-flop sync, reset 0; latency 2 swclk edges.
// STRUCTURE
// - Shared package/header: DP address constants, CTRL/STAT bit indices, ABORT bit indices,
//   DPBANKSEL encodings.
// - One sub-module: opendap_sync_2ff, instantiated for each power ack.
// - Everything else is flat: register file, decode, AP FSM (IDLE/BUSY).
// TESTING
// - DPIDR read after reset -> bus_rdata=32'h2ba01477 in the bus_en cycle; ap_rdy=1, fault=0.
// - Write SELECT=0x0500_0010, then AP read addr1 ->
//   ap_req with ap_sel=0x05, ap_addr=6'h05, ap_r_nw=1; ap_rdy=0 until ap_ack.
//   Ack with ap_rdata=0xCAFEF00D -> RDBUFF read returns 0xCAFEF00D and READOK=1.
// - AP write acked with ap_err=1 -> STICKYERR=1 and the next AP header sees dp_acc_fault=1.
//   ABORT write 0x04 -> STICKYERR=0 and fault=0.
// - dp_set_stickyorun and an ABORT write 0x10 in the same cycle -> STICKYORUN stays 1.
// - ABORT 0x01 while ap_req is pending, with ap_ack in the same cycle ->
//   ap_abort pulses, ap_req=0 next cycle, rdbuff unchanged.
// - Write CTRL/STAT 0x5000_0001 -> cdbgpwrupreq=csyspwrupreq=1 and ORUNDETECT=1.
//   Raise both acks -> CTRL/STAT reads 0xF000_0001 two cycles later.
//   Write addr1 with SELECT bank=2 -> protocol_err=1.

Source files
------------

// File: rtl/opendap_sw_dp_regs_pkg.sv
// Shared constants and types for the SW-DP register file: DP addresses, CTRL/STAT and
// ABORT bit positions, DPBANKSEL encodings and the latched AP command.
package opendap_sw_dp_regs_pkg;

  localparam logic [1:0] DP_ADDR_DPIDR     = 2'd0;
  localparam logic [1:0] DP_ADDR_ABORT     = 2'd0;
  localparam logic [1:0] DP_ADDR_CTRLSTAT  = 2'd1;
  localparam logic [1:0] DP_ADDR_RESEND    = 2'd2;
  localparam logic [1:0] DP_ADDR_SELECT    = 2'd2;
  localparam logic [1:0] DP_ADDR_RDBUFF    = 2'd3;
  localparam logic [1:0] DP_ADDR_TARGETSEL = 2'd3;

  localparam logic [3:0] DPBANK_CTRLSTAT = 4'd0;
  localparam logic [3:0] DPBANK_DLCR     = 4'd1;
  localparam logic [3:0] DPBANK_TARGETID = 4'd2;
  localparam logic [3:0] DPBANK_DLPIDR   = 4'd3;

  localparam int CS_ORUNDETECT   = 0;
  localparam int CS_STICKYORUN   = 1;
  localparam int CS_STICKYERR    = 5;
  localparam int CS_READOK       = 6;
  localparam int CS_WDATAERR     = 7;
  localparam int CS_CDBGPWRUPREQ = 28;
  localparam int CS_CDBGPWRUPACK = 29;
  localparam int CS_CSYSPWRUPREQ = 30;
  localparam int CS_CSYSPWRUPACK = 31;

  localparam int AB_DAPABORT   = 0;
  localparam int AB_STKERRCLR  = 2;
  localparam int AB_WDERRCLR   = 3;
  localparam int AB_ORUNERRCLR = 4;

  localparam logic [31:0] DLCR_VALUE = 32'h0000_0040;

  typedef enum logic {
    AP_IDLE = 1'b0,
    AP_BUSY = 1'b1
  } ap_state_t;

  typedef struct packed {
    logic [7:0]  sel;
    logic [5:0]  addr;
    logic        r_nw;
    logic [31:0] wdata;
  } ap_cmd_t;

endpackage

// File: rtl/opendap_sw_dp_regs_if.sv
// Parallel DP/AP access bus between the SW-DP serial engine (master) and the register file.
interface opendap_sw_dp_regs_if;
  logic [1:0]  bus_addr;
  logic        bus_r_nw;
  logic        bus_ap_ndp;
  logic [31:0] bus_wdata;
  logic        bus_en;
  logic [31:0] bus_rdata;

  modport master (
    output bus_addr, bus_r_nw, bus_ap_ndp, bus_wdata, bus_en,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr, bus_r_nw, bus_ap_ndp, bus_wdata, bus_en,
    output bus_rdata
  );
endinterface

// File: rtl/opendap_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the swclk domain.
module opendap_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/opendap_sw_dp_regs.sv
// SW-DP register file and posted AP-access sequencer. Reads are combinational in the
// access cycle; AP transactions run on a req/ack bus with results landing in RDBUFF.
module opendap_sw_dp_regs
  import opendap_sw_dp_regs_pkg::*;
#(
  parameter logic [31:0] DPIDR    = 32'h2ba01477,
  parameter logic [31:0] TARGETID = 32'h00000001,
  parameter logic [31:0] DLPIDR   = 32'h00000001
) (
  input  logic                       swclk,
  input  logic                       rst,
  opendap_sw_dp_regs_if.slave        bus,
  input  logic                       dp_set_wdataerr,
  input  logic                       dp_set_stickyorun,
  input  logic                       dp_clear_readok,
  output logic                       dp_orundetect,
  output logic                       dp_acc_fault,
  output logic                       dp_acc_protocol_err,
  output logic                       ap_rdy,
  output logic                       ap_req,
  output logic [7:0]                 ap_sel,
  output logic [5:0]                 ap_addr,
  output logic                       ap_r_nw,
  output logic [31:0]                ap_wdata,
  input  logic                       ap_ack,
  input  logic                       ap_err,
  input  logic [31:0]                ap_rdata,
  output logic                       ap_abort,
  output logic                       cdbgpwrupreq,
  output logic                       csyspwrupreq,
  input  logic                       cdbgpwrupack,
  input  logic                       csyspwrupack
);

  // Only the SELECT fields that something consumes are stored.
  logic [7:0]  sel_apsel;
  logic [3:0]  sel_apbank;
  logic [3:0]  sel_dpbank;
  logic        orundetect, stickyorun, stickyerr, readok, wdataerr;
  logic [31:0] rdbuff;
  logic [1:0]  pwrack_raw, pwrack_s;

  ap_state_t   ap_state, ap_state_nxt;
  ap_cmd_t     ap_cmd;
  logic        ap_busy;

  logic        dp_wr, abort_wr, ctrl_wr, select_wr, dapabort;
  logic        ap_launch, ap_done, ap_rd_ok, ap_rd_err;
  logic        clr_stkerr, clr_wderr, clr_orun;
  logic [31:0] ctrlstat, rd_mux;

  // Power-up acks
  assign pwrack_raw = {csyspwrupack, cdbgpwrupack};

  for (genvar i = 0; i < 2; i++) begin : g_pwrack_sync
    opendap_sync_2ff u_sync (
      .clk (swclk),
      .rst (rst),
      .d   (pwrack_raw[i]),
      .q   (pwrack_s[i])
    );
  end

  // Access decode
  assign dp_wr      = bus.bus_en && !bus.bus_ap_ndp && !bus.bus_r_nw;
  assign abort_wr   = dp_wr && (bus.bus_addr == DP_ADDR_ABORT);
  assign select_wr  = dp_wr && (bus.bus_addr == DP_ADDR_SELECT);
  assign ctrl_wr    = dp_wr && (bus.bus_addr == DP_ADDR_CTRLSTAT) && (sel_dpbank == DPBANK_CTRLSTAT);
  assign dapabort   = abort_wr && bus.bus_wdata[AB_DAPABORT];
  assign clr_stkerr = abort_wr && bus.bus_wdata[AB_STKERRCLR];
  assign clr_wderr  = abort_wr && bus.bus_wdata[AB_WDERRCLR];
  assign clr_orun   = abort_wr && bus.bus_wdata[AB_ORUNERRCLR];

  assign dp_acc_protocol_err = !bus.bus_ap_ndp && !bus.bus_r_nw &&
                               (bus.bus_addr == DP_ADDR_CTRLSTAT) &&
                               (sel_dpbank != DPBANK_CTRLSTAT);
  assign dp_acc_fault = bus.bus_ap_ndp && (stickyerr || stickyorun || wdataerr);

  // An AP access arriving while busy is dropped; an ack coinciding with DAPABORT is discarded.
  assign ap_launch = bus.bus_en && bus.bus_ap_ndp && !ap_busy;
  assign ap_done   = ap_busy && ap_ack && !dapabort;
  assign ap_rd_ok  = ap_done && ap_cmd.r_nw && !ap_err;
  assign ap_rd_err = ap_done && ap_cmd.r_nw && ap_err;
  assign ap_abort  = dapabort;

  // AP FSM
  always_ff @(posedge swclk or posedge rst) begin
    if (rst) ap_state <= AP_IDLE;
    else     ap_state <= ap_state_nxt;
  end

  always_comb begin
    ap_state_nxt = ap_state;
    case (ap_state)
      AP_IDLE: if (ap_launch)          ap_state_nxt = AP_BUSY;
      AP_BUSY: if (dapabort || ap_ack) ap_state_nxt = AP_IDLE;
    endcase
  end

  always_comb begin
    ap_busy = (ap_state == AP_BUSY);
    ap_req  = ap_busy;
    ap_rdy  = !ap_busy;
  end

  always_ff @(posedge swclk or posedge rst) begin
    if (rst) begin
      ap_cmd <= '0;
    end else if (ap_launch) begin
      ap_cmd.sel   <= sel_apsel;
      ap_cmd.addr  <= {sel_apbank, bus.bus_addr};
      ap_cmd.r_nw  <= bus.bus_r_nw;
      ap_cmd.wdata <= bus.bus_wdata;
    end
  end

  assign ap_sel   = ap_cmd.sel;
  assign ap_addr  = ap_cmd.addr;
  assign ap_r_nw  = ap_cmd.r_nw;
  assign ap_wdata = ap_cmd.wdata;

  // Register file; sticky sets win over ABORT clears in the same cycle.
  always_ff @(posedge swclk or posedge rst) begin
    if (rst) begin
      sel_apsel    <= '0;
      sel_apbank   <= '0;
      sel_dpbank   <= '0;
      orundetect   <= 1'b0;
      cdbgpwrupreq <= 1'b0;
      csyspwrupreq <= 1'b0;
      stickyerr    <= 1'b0;
      stickyorun   <= 1'b0;
      wdataerr     <= 1'b0;
      readok       <= 1'b0;
      rdbuff       <= '0;
    end else begin
      if (select_wr) begin
        sel_apsel  <= bus.bus_wdata[31:24];
        sel_apbank <= bus.bus_wdata[7:4];
        sel_dpbank <= bus.bus_wdata[3:0];
      end
      if (ctrl_wr) begin
        orundetect   <= bus.bus_wdata[CS_ORUNDETECT];
        cdbgpwrupreq <= bus.bus_wdata[CS_CDBGPWRUPREQ];
        csyspwrupreq <= bus.bus_wdata[CS_CSYSPWRUPREQ];
      end
      stickyerr  <= (ap_done && ap_err) || (stickyerr && !clr_stkerr);
      stickyorun <= dp_set_stickyorun   || (stickyorun && !clr_orun);
      wdataerr   <= dp_set_wdataerr     || (wdataerr && !clr_wderr);
      if (ap_rd_ok)                           readok <= 1'b1;
      else if (dp_clear_readok || ap_rd_err)  readok <= 1'b0;
      if (ap_rd_ok) rdbuff <= ap_rdata;
    end
  end

  assign dp_orundetect = orundetect;

  // Read path
  always_comb begin
    ctrlstat                  = '0;
    ctrlstat[CS_ORUNDETECT]   = orundetect;
    ctrlstat[CS_STICKYORUN]   = stickyorun;
    ctrlstat[CS_STICKYERR]    = stickyerr;
    ctrlstat[CS_READOK]       = readok;
    ctrlstat[CS_WDATAERR]     = wdataerr;
    ctrlstat[CS_CDBGPWRUPREQ] = cdbgpwrupreq;
    ctrlstat[CS_CDBGPWRUPACK] = pwrack_s[0];
    ctrlstat[CS_CSYSPWRUPREQ] = csyspwrupreq;
    ctrlstat[CS_CSYSPWRUPACK] = pwrack_s[1];

    rd_mux = '0;
    if (bus.bus_ap_ndp) begin
      rd_mux = rdbuff;
    end else begin
      case (bus.bus_addr)
        DP_ADDR_DPIDR:    rd_mux = DPIDR;
        DP_ADDR_CTRLSTAT: begin
          case (sel_dpbank)
            DPBANK_CTRLSTAT: rd_mux = ctrlstat;
            DPBANK_DLCR:     rd_mux = DLCR_VALUE;
            DPBANK_TARGETID: rd_mux = TARGETID;
            DPBANK_DLPIDR:   rd_mux = DLPIDR;
            default:         rd_mux = '0;
          endcase
        end
        DP_ADDR_RESEND:   rd_mux = '0;
        default:          rd_mux = rdbuff;
      endcase
    end
    bus.bus_rdata = (bus.bus_en && bus.bus_r_nw) ? rd_mux : '0;
  end

endmodule

// File: tb/tb_opendap_sw_dp_regs.sv
// Scoreboard bench: stimulus queues expected read data, AP launches and status snapshots;
// a negedge monitor pops and compares whenever the DUT presents the matching output.
module tb_opendap_sw_dp_regs;

  logic        swclk = 1'b0;
  logic        rst   = 1'b1;
  logic        dp_set_wdataerr, dp_set_stickyorun, dp_clear_readok;
  logic        dp_orundetect, dp_acc_fault, dp_acc_protocol_err;
  logic        ap_rdy, ap_req, ap_r_nw, ap_ack, ap_err, ap_abort;
  logic [7:0]  ap_sel;
  logic [5:0]  ap_addr;
  logic [31:0] ap_wdata, ap_rdata;
  logic        cdbgpwrupreq, csyspwrupreq, cdbgpwrupack, csyspwrupack;

  always #5 swclk = ~swclk;

  opendap_sw_dp_regs_if bus_if ();

  opendap_sw_dp_regs dut (
    .swclk               (swclk),
    .rst                 (rst),
    .bus                 (bus_if.slave),
    .dp_set_wdataerr     (dp_set_wdataerr),
    .dp_set_stickyorun   (dp_set_stickyorun),
    .dp_clear_readok     (dp_clear_readok),
    .dp_orundetect       (dp_orundetect),
    .dp_acc_fault        (dp_acc_fault),
    .dp_acc_protocol_err (dp_acc_protocol_err),
    .ap_rdy              (ap_rdy),
    .ap_req              (ap_req),
    .ap_sel              (ap_sel),
    .ap_addr             (ap_addr),
    .ap_r_nw             (ap_r_nw),
    .ap_wdata            (ap_wdata),
    .ap_ack              (ap_ack),
    .ap_err              (ap_err),
    .ap_rdata            (ap_rdata),
    .ap_abort            (ap_abort),
    .cdbgpwrupreq        (cdbgpwrupreq),
    .csyspwrupreq        (csyspwrupreq),
    .cdbgpwrupack        (cdbgpwrupack),
    .csyspwrupack        (csyspwrupack)
  );

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  exp_t rd_q[$];
  exp_t ap_q[$];
  exp_t st_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic chk_stb = 1'b0;
  logic req_seen = 1'b0;

  // {ap_rdy, ap_req, ap_abort, fault, protocol_err, orundetect, cdbgpwrupreq, csyspwrupreq}
  wire [7:0] status = {ap_rdy, ap_req, ap_abort, dp_acc_fault, dp_acc_protocol_err,
                       dp_orundetect, cdbgpwrupreq, csyspwrupreq};

  function automatic void compare(string name, logic [63:0] got, logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endfunction

  function automatic void unexpected(string name, logic [63:0] got);
    n_chk++;
    $display("FAIL %s: got %0h want no output", name, got);
  endfunction

  // Monitor
  always @(negedge swclk) begin
    exp_t e;
    if (!rst) begin
      if (bus_if.bus_en && bus_if.bus_r_nw) begin
        if (rd_q.size() == 0) unexpected("rd_unexpected", {32'h0, bus_if.bus_rdata});
        else begin
          e = rd_q.pop_front();
          compare(e.name, {32'h0, bus_if.bus_rdata}, e.val);
        end
      end
      if (ap_req && !req_seen) begin
        if (ap_q.size() == 0) unexpected("ap_unexpected", {17'h0, ap_sel, ap_addr, ap_r_nw, ap_wdata});
        else begin
          e = ap_q.pop_front();
          compare(e.name, {17'h0, ap_sel, ap_addr, ap_r_nw, ap_wdata}, e.val);
        end
      end
      req_seen <= ap_req;
      if (chk_stb) begin
        if (st_q.size() == 0) unexpected("st_unexpected", {56'h0, status});
        else begin
          e = st_q.pop_front();
          compare(e.name, {56'h0, status}, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge swclk);
    #1;
    bus_if.bus_en     = 1'b0;
    bus_if.bus_ap_ndp = 1'b0;
    bus_if.bus_r_nw   = 1'b1;
    bus_if.bus_addr   = 2'd0;
    bus_if.bus_wdata  = 32'h0;
    chk_stb           = 1'b0;
    dp_set_wdataerr   = 1'b0;
    dp_set_stickyorun = 1'b0;
    dp_clear_readok   = 1'b0;
    ap_ack            = 1'b0;
    ap_err            = 1'b0;
    ap_rdata          = 32'h0;
  endtask

  task automatic drv(input logic ap_ndp, input logic r_nw, input logic [1:0] addr,
                     input logic [31:0] wdata);
    bus_if.bus_en     = 1'b1;
    bus_if.bus_ap_ndp = ap_ndp;
    bus_if.bus_r_nw   = r_nw;
    bus_if.bus_addr   = addr;
    bus_if.bus_wdata  = wdata;
  endtask

  task automatic exp_rd(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n; e.val = {32'h0, v};
    rd_q.push_back(e);
  endtask

  task automatic exp_st(input string n, input logic [7:0] v);
    exp_t e;
    e.name = n; e.val = {56'h0, v};
    st_q.push_back(e);
    chk_stb = 1'b1;
  endtask

  task automatic exp_ap(input string n, input logic [7:0] sel, input logic [5:0] addr,
                        input logic rnw, input logic [31:0] wd);
    exp_t e;
    e.name = n; e.val = {17'h0, sel, addr, rnw, wd};
    ap_q.push_back(e);
  endtask

  task automatic dp_rd(input logic [1:0] addr, input logic [31:0] v, input string n);
    drv(1'b0, 1'b1, addr, 32'h0);
    exp_rd(n, v);
    tick();
  endtask

  task automatic dp_wr(input logic [1:0] addr, input logic [31:0] d);
    drv(1'b0, 1'b0, addr, d);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus_if.bus_en = 1'b0; bus_if.bus_ap_ndp = 1'b0; bus_if.bus_r_nw = 1'b1;
    bus_if.bus_addr = 2'd0; bus_if.bus_wdata = 32'h0;
    dp_set_wdataerr = 1'b0; dp_set_stickyorun = 1'b0; dp_clear_readok = 1'b0;
    ap_ack = 1'b0; ap_err = 1'b0; ap_rdata = 32'h0;
    cdbgpwrupack = 1'b0; csyspwrupack = 1'b0;
    repeat (3) @(posedge swclk);
    #1 rst = 1'b0;

    // Reset state and DPIDR
    exp_st("reset_status", 8'b1000_0000);
    tick();
    drv(1'b0, 1'b1, 2'd0, 32'h0);
    exp_rd("dpidr", 32'h2ba01477);
    exp_st("dpidr_status", 8'b1000_0000);
    tick();
    dp_rd(2'd3, 32'h0, "rdbuff_reset");
    dp_rd(2'd1, 32'h0, "ctrlstat_reset");

    // Posted AP read
    dp_wr(2'd2, 32'h0500_0010);
    drv(1'b1, 1'b1, 2'd1, 32'h0);
    exp_rd("ap_rd1_posted", 32'h0);
    exp_ap("ap_rd1_launch", 8'h05, 6'h05, 1'b1, 32'h0);
    tick();
    exp_st("ap_rd1_busy", 8'b0100_0000);
    tick();
    ap_ack = 1'b1; ap_rdata = 32'hCAFE_F00D;
    exp_st("ap_rd1_ack_cycle", 8'b0100_0000);
    tick();
    exp_st("ap_rd1_done", 8'b1000_0000);
    tick();
    dp_rd(2'd3, 32'hCAFE_F00D, "rdbuff_after_rd1");
    dp_rd(2'd1, 32'h0000_0040, "readok_set");

    // AP write with slave error
    drv(1'b1, 1'b0, 2'd2, 32'h1234_5678);
    exp_ap("ap_wr_launch", 8'h05, 6'h06, 1'b0, 32'h1234_5678);
    tick();
    tick();
    ap_ack = 1'b1; ap_err = 1'b1;
    tick();
    bus_if.bus_ap_ndp = 1'b1;
    exp_st("fault_stickyerr", 8'b1001_0000);
    tick();
    dp_rd(2'd1, 32'h0000_0060, "stickyerr_set");
    dp_wr(2'd0, 32'h0000_0004);
    bus_if.bus_ap_ndp = 1'b1;
    exp_st("fault_cleared", 8'b1000_0000);
    tick();

    // Sticky set beats ABORT clear
    drv(1'b0, 1'b0, 2'd0, 32'h0000_0010);
    dp_set_stickyorun = 1'b1;
    tick();
    dp_rd(2'd1, 32'h0000_0042, "stickyorun_set_wins");
    bus_if.bus_ap_ndp = 1'b1;
    exp_st("fault_stickyorun", 8'b1001_0000);
    tick();
    dp_set_wdataerr = 1'b1;
    tick();
    dp_rd(2'd1, 32'h0000_00C2, "wdataerr_set");
    drv(1'b0, 1'b0, 2'd0, 32'h0000_001C);
    dp_clear_readok = 1'b1;
    tick();
    dp_rd(2'd1, 32'h0, "all_sticky_cleared");

    // READOK set beats dp_clear_readok
    drv(1'b1, 1'b1, 2'd0, 32'h0);
    exp_rd("ap_rd2_posted", 32'hCAFE_F00D);
    exp_ap("ap_rd2_launch", 8'h05, 6'h04, 1'b1, 32'h0);
    tick();
    tick();
    ap_ack = 1'b1; ap_rdata = 32'h1111_2222; dp_clear_readok = 1'b1;
    tick();
    dp_rd(2'd1, 32'h0000_0040, "readok_set_wins");
    dp_rd(2'd3, 32'h1111_2222, "rdbuff_after_rd2");

    // DAPABORT with a coincident ack
    drv(1'b1, 1'b1, 2'd1, 32'h0);
    exp_rd("ap_rd3_posted", 32'h1111_2222);
    exp_ap("ap_rd3_launch", 8'h05, 6'h05, 1'b1, 32'h0);
    tick();
    tick();
    drv(1'b0, 1'b0, 2'd0, 32'h0000_0001);
    ap_ack = 1'b1; ap_rdata = 32'hDEAD_BEEF;
    exp_st("abort_pulse", 8'b0110_0000);
    tick();
    exp_st("abort_after", 8'b1000_0000);
    tick();
    dp_rd(2'd3, 32'h1111_2222, "rdbuff_abort_unchanged");
    dp_rd(2'd1, 32'h0000_0040, "ctrlstat_abort_unchanged");

    // Power requests and synchronised acks
    drv(1'b0, 1'b0, 2'd1, 32'h5000_0001);
    dp_clear_readok = 1'b1;
    tick();
    cdbgpwrupack = 1'b1; csyspwrupack = 1'b1;
    exp_st("pwrupreq", 8'b1000_0111);
    tick();
    dp_rd(2'd1, 32'h5000_0001, "pwrack_one_edge");
    dp_rd(2'd1, 32'hF000_0001, "pwrack_two_edges");

    // DP banks and protocol error
    dp_wr(2'd2, 32'h0000_0012);
    dp_rd(2'd1, 32'h0000_0001, "targetid");
    drv(1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF);
    exp_st("protocol_err", 8'b1000_1111);
    tick();
    dp_wr(2'd2, 32'h0000_0001);
    dp_rd(2'd1, 32'h0000_0040, "dlcr");
    dp_wr(2'd2, 32'h0000_0003);
    dp_rd(2'd1, 32'h0000_0001, "dlpidr");
    dp_wr(2'd2, 32'h0000_0005);
    dp_rd(2'd1, 32'h0, "bank_reserved");
    dp_wr(2'd2, 32'h0000_0000);
    dp_rd(2'd1, 32'hF000_0001, "ctrlstat_not_written");
    dp_rd(2'd2, 32'h0, "resend");

    tick();
    tick();
    compare("rd_q_drained", 64'(rd_q.size()), 64'd0);
    compare("ap_q_drained", 64'(ap_q.size()), 64'd0);
    compare("st_q_drained", 64'(st_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
